regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 134 +++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with per-register pending-write scoreboard.
// Register 0 is hardwired to zero and is always ready. Each other register counts
// outstanding writes: an invalidation increments the count and a writeback
// decrements it. Reads take one cycle and also return the ready state.
// Optional feature: define REGFILE_SB_BYPASS_EN to forward a same-cycle writeback
// to a read of the same register, together with the post-writeback ready state.
module regfile_sb #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned NRD   = 2,
   parameter int unsigned PW    = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NRD-1:0]               rd_en,
   input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
   output logic [NRD*XLEN-1:0]          rd_data,
   output logic [NRD-1:0]               rd_vld,
   output logic [NRD-1:0]               rd_rdy,
   input  logic                         wb_en,
   input  logic [$clog2(NREGS)-1:0]     wb_addr,
   input  logic [XLEN-1:0]              wb_data,
   input  logic                         inv_en,
   input  logic [$clog2(NREGS)-1:0]     inv_addr,
   output logic                         source_not_ready,
   output logic                         inv_ovf,
   output logic                         wb_err
);

   localparam int unsigned AW       = $clog2(NREGS);
   localparam logic [PW-1:0] PEND_MAX = {PW{1'b1}};

   logic [XLEN-1:0] regs     [NREGS];
   logic [PW-1:0]   pend     [NREGS];
   logic [PW-1:0]   pend_nxt [NREGS];

   logic            wb_hit;
   logic            inv_hit;
   logic            wb_inv_same;
   logic            wb_err_nxt;
   logic            inv_ovf_nxt;

   logic [AW-1:0]   ra        [NRD];
   logic [XLEN-1:0] rdata_nxt [NRD];
   logic            rrdy_nxt  [NRD];

   // Register 0 never takes writes or invalidations.
   assign wb_hit      = wb_en  && (wb_addr  != '0);
   assign inv_hit     = inv_en && (inv_addr != '0);
   // An issue and a completion on the same register cancel out.
   assign wb_inv_same = wb_hit && inv_hit && (wb_addr == inv_addr);

   // Next pending counts and error pulse conditions.
   always_comb begin
      pend_nxt    = pend;
      wb_err_nxt  = 1'b0;
      inv_ovf_nxt = 1'b0;
      if (!wb_inv_same) begin
         if (wb_hit) begin
            if (pend[wb_addr] == '0) begin
               wb_err_nxt = 1'b1;
            end else begin
               pend_nxt[wb_addr] = pend[wb_addr] - PW'(1);
            end
         end
         if (inv_hit) begin
            if (pend[inv_addr] == PEND_MAX) begin
               inv_ovf_nxt = 1'b1;
            end else begin
               pend_nxt[inv_addr] = pend[inv_addr] + PW'(1);
            end
         end
      end
   end

   // Per-port read address decode and lookup of data and ready state.
   for (genvar g = 0; g < NRD; g++) begin : g_rd
      assign ra[g] = rd_addr[g*AW +: AW];

      // Read value; ready reflects the counter before this cycle's updates.
      always_comb begin
         rdata_nxt[g] = regs[ra[g]];
         rrdy_nxt[g]  = (pend[ra[g]] == '0);
`ifdef REGFILE_SB_BYPASS_EN
         if (wb_hit && (wb_addr == ra[g])) begin
            rdata_nxt[g] = wb_data;
            rrdy_nxt[g]  = (pend_nxt[ra[g]] == '0);
         end
`endif
      end
   end

   // Register array, pending counters and one-cycle error pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
            pend[r] <= '0;
         end
         wb_err  <= 1'b0;
         inv_ovf <= 1'b0;
      end else begin
         if (wb_hit) begin
            regs[wb_addr] <= wb_data;
         end
         for (int unsigned r = 0; r < NREGS; r++) begin
            pend[r] <= pend_nxt[r];
         end
         wb_err  <= wb_err_nxt;
         inv_ovf <= inv_ovf_nxt;
      end
   end

   // Registered read ports; data holds when a port is idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= '0;
         rd_vld  <= '0;
         rd_rdy  <= '0;
      end else begin
         rd_vld <= rd_en;
         for (int unsigned i = 0; i < NRD; i++) begin
            rd_rdy[i] <= rd_en[i] & rrdy_nxt[i];
            if (rd_en[i]) begin
               rd_data[i*XLEN +: XLEN] <= rdata_nxt[i];
            end
         end
      end
   end

   // Any valid read returned a not-ready operand.
   assign source_not_ready = |(rd_vld & ~rd_rdy);

endmodule
